router_rr: RTL and testbench
============================

ROUTER_RR -- requirements
Module: router_rr

Interface
REQ-001 The block SHALL have parameter NUM_PORTS, default 4, meaning the number of input ports and the number of output ports (2..8).
REQ-002 The block SHALL have parameter DATA_WIDTH, default 32, meaning the flit payload width (>= $clog2(NUM_PORTS)).
REQ-003 The block SHALL have parameter FIFO_DEPTH, default 4, meaning the flits per input FIFO (power of 2, >= 2).
REQ-004 The block SHALL have parameter DEST_LSB, default 0, meaning the payload bit where the destination port field starts; the field is $clog2(NUM_PORTS) bits wide.
REQ-005 The block SHALL use a single clock; reset is synchronous and active-high.
REQ-006 The block SHALL have these ports:
- clk  in  1  clock, all state on posedge.
- rst  in  1  synchronous active-high reset.
- in_valid  in  NUM_PORTS  per-input flit valid.
- in_type  in  2*NUM_PORTS  per-input flit type: 01 head, 00 body, 10 tail, 11 single.
- in_data  in  DATA_WIDTH*NUM_PORTS  per-input payload.
- in_ready  out  NUM_PORTS  per-input ready.
- out_valid  out  NUM_PORTS  per-output valid.
- out_type  out  2*NUM_PORTS  per-output flit type.
- out_data  out  DATA_WIDTH*NUM_PORTS  per-output payload.
- out_ready  in  NUM_PORTS  per-output ready.
- drop_pulse  out  NUM_PORTS  one-cycle pulse per discarded malformed flit.
Port i occupies slice [i*W +: W] of each bus.

Function
REQ-007 Transfers SHALL occur on a posedge where valid and ready are both 1.
REQ-008 Each input SHALL have a FIFO of depth FIFO_DEPTH; in_ready[i] SHALL equal !full with no pop bypass. Push and pop in the same cycle SHALL leave the count unchanged.
REQ-009 Each output SHALL have FSM states IDLE and BUSY plus a registered grant index.
REQ-010 In IDLE, candidates SHALL be the inputs that are not granted to any output, whose FIFO is non-empty, whose head flit type is 01 or 11, and whose destination field equals this output.
- Round-robin selection SHALL start at rr_ptr.
- The winner SHALL be registered as grant, the state SHALL become BUSY, and rr_ptr SHALL become (winner+1) mod NUM_PORTS.
- With no candidates, the output SHALL stay IDLE.
REQ-011 In BUSY, out_valid/out_type/out_data SHALL equal the granted FIFO's non-empty/head type/head data. A transfer SHALL pop that FIFO.
REQ-012 On transfer of type 10 or 11, the output SHALL return to IDLE on the next cycle. Head flits (01) seen mid-packet SHALL be forwarded as body.
REQ-013 Outputs SHALL hold stable while out_valid=1 and out_ready=0.
REQ-014 Minimum latency SHALL be 2 cycles: a flit pushed at edge N SHALL be arbitrated at edge N+1 and present with out_valid=1 during cycle N+2. A BUSY output SHALL then sustain 1 flit/cycle.
REQ-015 An ungranted input whose FIFO head type is 00 or 10 SHALL pop that flit. drop_pulse[i] SHALL be 1 in the cycle after the pop.
REQ-016 An input SHALL be granted to at most one output at a time. Outputs SHALL arbitrate independently and concurrently.
REQ-017 An empty granted FIFO mid-packet SHALL hold out_valid=0 and keep the grant.

Reset
REQ-018 While rst=1 at a posedge, all FIFOs SHALL empty, all FSMs SHALL go IDLE, and all rr_ptr SHALL become 0.
REQ-019 While rst=1, in_ready, out_valid, and drop_pulse SHALL be 0, and out_type/out_data SHALL be 0.
REQ-020 In the cycle after rst falls, in_ready SHALL be all 1.
REQ-021 Reset mid-packet SHALL discard buffered flits and release all grants; no partial packet SHALL be emitted afterwards.

Verification
REQ-022 Single: in0 pushes type 11, data 0x2 (dest 2) at edge N -> out_valid[2]=1 in cycle N+2 with data 0x2; IDLE again after the transfer.
REQ-023 Wormhole: in1 sends head dest 3, body 0xA, tail 0xB while in2 sends a single to dest 3 one cycle later -> out3 emits the three in1 flits contiguously, then the in2 single.
REQ-024 Round-robin: in0..in3 each hold a single to dest 0 continuously -> grant order 0,1,2,3,0, each packet's transfer seen.
REQ-025 Backpressure/full: out_ready[1]=0, in0 streams a 6-flit packet to dest 1 with FIFO_DEPTH=4 -> in_ready[0]=0 after 4 pushes (head forwarded but held); out data stable; all 6 flits arrive in order once ready=1.
REQ-026 Malformed and reset: a body flit sent to idle in3 -> drop_pulse[3] single pulse, no out_valid. rst asserted mid-packet -> all out_valid=0, in_ready=0, and after release no remnant flits appear.

Source files
------------

// File: rtl/router_rr.sv
// Wormhole router with NUM_PORTS inputs and outputs. Each input has a flit FIFO.
// Each output runs its own round-robin arbiter and holds a grant until the packet ends.
module router_rr #(
  parameter int unsigned NUM_PORTS  = 4,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned DEST_LSB   = 0
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [NUM_PORTS-1:0]            in_valid,
  input  logic [2*NUM_PORTS-1:0]          in_type,
  input  logic [DATA_WIDTH*NUM_PORTS-1:0] in_data,
  output logic [NUM_PORTS-1:0]            in_ready,
  output logic [NUM_PORTS-1:0]            out_valid,
  output logic [2*NUM_PORTS-1:0]          out_type,
  output logic [DATA_WIDTH*NUM_PORTS-1:0] out_data,
  input  logic [NUM_PORTS-1:0]            out_ready,
  output logic [NUM_PORTS-1:0]            drop_pulse
);

  localparam int unsigned PW = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
  localparam int unsigned AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CW = AW + 1;

  localparam logic [1:0] T_BODY = 2'b00;
  localparam logic [1:0] T_HEAD = 2'b01;

  typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

  typedef struct packed {
    logic [1:0]            ftype;
    logic [DATA_WIDTH-1:0] data;
  } flit_t;

  flit_t                mem     [NUM_PORTS][FIFO_DEPTH];
  logic [AW-1:0]        wr_ptr  [NUM_PORTS];
  logic [AW-1:0]        rd_ptr  [NUM_PORTS];
  logic [CW-1:0]        count   [NUM_PORTS];
  flit_t                head    [NUM_PORTS];
  logic [PW-1:0]        dest    [NUM_PORTS];
  logic [NUM_PORTS-1:0] owner   [NUM_PORTS];  // owner[i][o]: output o holds input i
  logic [NUM_PORTS-1:0] fwd     [NUM_PORTS];  // fwd[i][o]: output o pops input i
  logic [NUM_PORTS-1:0] cand    [NUM_PORTS];  // cand[o][i]: input i requests output o

  logic [NUM_PORTS-1:0] not_empty, push, pop, drop, granted, pop_fwd, eligible;

  state_t               state_q   [NUM_PORTS];
  state_t               state_nxt [NUM_PORTS];
  logic [PW-1:0]        grant_q   [NUM_PORTS];
  logic [PW-1:0]        grant_nxt [NUM_PORTS];
  logic [PW-1:0]        rr_q      [NUM_PORTS];
  logic [PW-1:0]        rr_nxt    [NUM_PORTS];
  logic [NUM_PORTS-1:0] first_q, first_nxt, busy, xfer;

  for (genvar i = 0; i < NUM_PORTS; i++) begin : g_in
    logic [CW-1:0] count_nxt;

    assign not_empty[i] = (count[i] != '0);
    assign head[i]      = mem[i][rd_ptr[i]];
    assign dest[i]      = head[i].data[DEST_LSB +: PW];
    assign push[i]      = in_valid[i] & in_ready[i];
    assign granted[i]   = |owner[i];
    assign pop_fwd[i]   = |fwd[i];
    // Type bit 0 set means head or single: the only flits allowed to open a packet.
    assign eligible[i]  = not_empty[i] & ~granted[i] & head[i].ftype[0];
    assign drop[i]      = not_empty[i] & ~granted[i] & ~head[i].ftype[0];
    assign pop[i]       = pop_fwd[i] | drop[i];
    assign count_nxt    = count[i] + CW'(push[i]) - CW'(pop[i]);

    always_ff @(posedge clk) begin
      if (push[i]) begin
        mem[i][wr_ptr[i]] <= {in_type[2*i +: 2], in_data[DATA_WIDTH*i +: DATA_WIDTH]};
      end
    end

    always_ff @(posedge clk) begin
      if (rst) begin
        wr_ptr[i]     <= '0;
        rd_ptr[i]     <= '0;
        count[i]      <= '0;
        in_ready[i]   <= 1'b0;
        drop_pulse[i] <= 1'b0;
      end else begin
        if (push[i]) wr_ptr[i] <= wr_ptr[i] + AW'(1);
        if (pop[i])  rd_ptr[i] <= rd_ptr[i] + AW'(1);
        count[i]      <= count_nxt;
        in_ready[i]   <= (count_nxt != CW'(FIFO_DEPTH));
        drop_pulse[i] <= drop[i];
      end
    end
  end

  for (genvar o = 0; o < NUM_PORTS; o++) begin : g_out
    flit_t         cur;
    logic          vld;
    logic          found;
    logic [PW-1:0] idx;

    assign busy[o] = (state_q[o] == BUSY);
    assign cur     = head[grant_q[o]];
    assign vld     = ~rst & busy[o] & not_empty[grant_q[o]];
    assign xfer[o] = vld & out_ready[o];

    assign out_valid[o]                          = vld;
    assign out_data[DATA_WIDTH*o +: DATA_WIDTH]  = vld ? cur.data : '0;
    // A head arriving after the packet opened is passed on as a body flit.
    assign out_type[2*o +: 2] = !vld ? 2'b00 :
                                (!first_q[o] && cur.ftype == T_HEAD) ? T_BODY : cur.ftype;

    for (genvar i = 0; i < NUM_PORTS; i++) begin : g_x
      assign owner[i][o] = busy[o] && (grant_q[o] == PW'(i));
      assign fwd[i][o]   = owner[i][o] & xfer[o];
      assign cand[o][i]  = eligible[i] && (dest[i] == PW'(o));
    end

    always_comb begin
      state_nxt[o] = state_q[o];
      grant_nxt[o] = grant_q[o];
      rr_nxt[o]    = rr_q[o];
      first_nxt[o] = first_q[o];
      found        = 1'b0;
      idx          = '0;
      case (state_q[o])
        IDLE: begin
          for (int unsigned k = 0; k < NUM_PORTS; k++) begin
            idx = PW'((32'(rr_q[o]) + k) % NUM_PORTS);
            if (!found && cand[o][idx]) begin
              found        = 1'b1;
              grant_nxt[o] = idx;
              rr_nxt[o]    = PW'((32'(idx) + 32'd1) % NUM_PORTS);
              state_nxt[o] = BUSY;
              first_nxt[o] = 1'b1;
            end
          end
        end
        BUSY: begin
          if (xfer[o]) begin
            first_nxt[o] = 1'b0;
            // Type bit 1 set means tail or single: the packet closes here.
            if (cur.ftype[1]) state_nxt[o] = IDLE;
          end
        end
        default: state_nxt[o] = IDLE;
      endcase
    end

    always_ff @(posedge clk) begin
      if (rst) begin
        state_q[o] <= IDLE;
        grant_q[o] <= '0;
        rr_q[o]    <= '0;
        first_q[o] <= 1'b0;
      end else begin
        state_q[o] <= state_nxt[o];
        grant_q[o] <= grant_nxt[o];
        rr_q[o]    <= rr_nxt[o];
        first_q[o] <= first_nxt[o];
      end
    end
  end

endmodule

// File: tb/tb_router_rr.sv
// Scoreboard bench for router_rr: per-output expected-flit queues, checked on transfer.
module tb_router_rr;

  localparam int NP = 4;
  localparam int DW = 32;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic [NP-1:0]   in_valid = '0;
  logic [2*NP-1:0] in_type  = '0;
  logic [DW*NP-1:0] in_data = '0;
  logic [NP-1:0]   in_ready;
  logic [NP-1:0]   out_valid;
  logic [2*NP-1:0] out_type;
  logic [DW*NP-1:0] out_data;
  logic [NP-1:0]   out_ready = '1;
  logic [NP-1:0]   drop_pulse;

  typedef struct packed {
    logic [1:0]    t;
    logic [DW-1:0] d;
  } exp_t;

  exp_t sb [NP][$];
  exp_t mon_e;
  int   checks = 0;
  int   errors = 0;

  router_rr #(.NUM_PORTS(NP), .DATA_WIDTH(DW), .FIFO_DEPTH(4), .DEST_LSB(0)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_type(in_type), .in_data(in_data), .in_ready(in_ready),
    .out_valid(out_valid), .out_type(out_type), .out_data(out_data), .out_ready(out_ready),
    .drop_pulse(drop_pulse)
  );

  always #5 clk = ~clk;

  // Scoreboard: every accepted output flit must match the head of its output's queue.
  always @(negedge clk) begin
    if (!rst) begin
      for (int o = 0; o < NP; o++) begin
        if (out_valid[o] && out_ready[o]) begin
          checks++;
          if (sb[o].size() == 0) begin
            errors++;
            $display("FAIL unexpected_flit out%0d got type %b data %h required none",
                     o, out_type[2*o +: 2], out_data[DW*o +: DW]);
          end else begin
            mon_e = sb[o].pop_front();
            if ({out_type[2*o +: 2], out_data[DW*o +: DW]} !== {mon_e.t, mon_e.d}) begin
              errors++;
              $display("FAIL flit_out%0d got type %b data %h required type %b data %h",
                       o, out_type[2*o +: 2], out_data[DW*o +: DW], mon_e.t, mon_e.d);
            end
          end
        end
      end
    end
  end

  task automatic expect_flit(input int o, input logic [1:0] t, input logic [DW-1:0] d);
    sb[o].push_back('{t: t, d: d});
  endtask

  // Called at posedge+1; returns at posedge+1 after the flit was accepted.
  task automatic put(input int p, input logic [1:0] t, input logic [DW-1:0] d);
    int n = 0;
    in_valid[p]         = 1'b1;
    in_type[2*p +: 2]   = t;
    in_data[DW*p +: DW] = d;
    @(negedge clk);
    while (!in_ready[p] && n < 300) begin
      n++;
      @(negedge clk);
    end
    if (n >= 300) begin
      checks++;
      errors++;
      $display("FAIL put_timeout in%0d got in_ready 0 required 1", p);
    end
    @(posedge clk);
    #1;
    in_valid[p] = 1'b0;
  endtask

  task automatic apply_reset();
    @(posedge clk);
    #1;
    rst      = 1'b1;
    in_valid = '0;
    for (int o = 0; o < NP; o++) sb[o].delete();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic wait_drain(input string name);
    int n = 0;
    while ((sb[0].size() + sb[1].size() + sb[2].size() + sb[3].size()) != 0 && n < 300) begin
      n++;
      @(negedge clk);
    end
    checks++;
    if (n >= 300) begin
      errors++;
      $display("FAIL drain_%s got %0d pending flits required 0", name,
               sb[0].size() + sb[1].size() + sb[2].size() + sb[3].size());
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({in_ready, out_valid, drop_pulse} !== '0 || out_type !== '0 || out_data !== '0) begin
      errors++;
      $display("FAIL reset_outputs got rdy %b vld %b drop %b type %b required all 0",
               in_ready, out_valid, drop_pulse, out_type);
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk);
    @(negedge clk);
    checks++;
    if (in_ready !== 4'hF) begin
      errors++;
      $display("FAIL reset_release_ready got %b required 1111", in_ready);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_single();
    apply_reset();
    expect_flit(2, 2'b11, 32'h2);
    in_valid[0] = 1'b1; in_type[1:0] = 2'b11; in_data[31:0] = 32'h2;
    @(posedge clk);
    #1;
    in_valid[0] = 1'b0;
    @(negedge clk);
    checks++;
    if (out_valid[2] !== 1'b0) begin
      errors++;
      $display("FAIL single_early got out_valid2 %b required 0", out_valid[2]);
    end
    @(negedge clk);
    checks++;
    if (out_valid[2] !== 1'b1 || out_data[95:64] !== 32'h2) begin
      errors++;
      $display("FAIL single_latency got vld %b data %h required 1 00000002",
               out_valid[2], out_data[95:64]);
    end
    @(negedge clk);
    checks++;
    if (out_valid[2] !== 1'b0) begin
      errors++;
      $display("FAIL single_idle got out_valid2 %b required 0", out_valid[2]);
    end
    @(posedge clk);
    #1;
    wait_drain("single");
  endtask

  task automatic test_wormhole();
    apply_reset();
    expect_flit(3, 2'b01, 32'h3);
    expect_flit(3, 2'b00, 32'hA);
    expect_flit(3, 2'b10, 32'hB);
    expect_flit(3, 2'b11, 32'h13);
    fork
      begin
        put(1, 2'b01, 32'h3);
        put(1, 2'b00, 32'hA);
        put(1, 2'b10, 32'hB);
      end
      begin
        @(posedge clk);
        #1;
        put(2, 2'b11, 32'h13);
      end
    join
    wait_drain("wormhole");
  endtask

  task automatic test_round_robin();
    apply_reset();
    for (int s = 0; s < 2; s++)
      for (int p = 0; p < NP; p++) expect_flit(0, 2'b11, 32'h100 * p + 32'h10 * s);
    fork
      begin put(0, 2'b11, 32'h000); put(0, 2'b11, 32'h010); end
      begin put(1, 2'b11, 32'h100); put(1, 2'b11, 32'h110); end
      begin put(2, 2'b11, 32'h200); put(2, 2'b11, 32'h210); end
      begin put(3, 2'b11, 32'h300); put(3, 2'b11, 32'h310); end
    join
    wait_drain("round_robin");
  endtask

  task automatic test_backpressure();
    int pushed = 0;
    bit done = 0;
    logic [1:0]    ts [6] = '{2'b01, 2'b00, 2'b01, 2'b00, 2'b00, 2'b10};
    logic [1:0]    te [6] = '{2'b01, 2'b00, 2'b00, 2'b00, 2'b00, 2'b10};
    logic [DW-1:0] ds [6] = '{32'h1001, 32'h2002, 32'h3003, 32'h4004, 32'h5005, 32'h6006};
    apply_reset();
    out_ready[1] = 1'b0;
    for (int k = 0; k < 6; k++) expect_flit(1, te[k], ds[k]);
    fork
      begin
        for (int k = 0; k < 6; k++) begin
          put(0, ts[k], ds[k]);
          pushed++;
        end
        done = 1;
      end
    join_none
    repeat (8) @(negedge clk);
    checks++;
    if (in_ready[0] !== 1'b0 || pushed != 4) begin
      errors++;
      $display("FAIL bp_full got in_ready0 %b pushes %0d required 0 4", in_ready[0], pushed);
    end
    checks++;
    if (out_valid[1] !== 1'b1 || out_type[3:2] !== 2'b01 || out_data[63:32] !== 32'h1001) begin
      errors++;
      $display("FAIL bp_hold got vld %b type %b data %h required 1 01 00001001",
               out_valid[1], out_type[3:2], out_data[63:32]);
    end
    repeat (3) @(negedge clk);
    checks++;
    if (out_valid[1] !== 1'b1 || out_data[63:32] !== 32'h1001) begin
      errors++;
      $display("FAIL bp_stable got vld %b data %h required 1 00001001",
               out_valid[1], out_data[63:32]);
    end
    @(posedge clk);
    #1;
    out_ready[1] = 1'b1;
    for (int n = 0; n < 300 && !done; n++) @(posedge clk);
    #1;
    checks++;
    if (!done) begin
      errors++;
      $display("FAIL bp_stream got pushes %0d required 6", pushed);
    end
    wait_drain("backpressure");
  endtask

  task automatic test_malformed();
    int pulses = 0;
    apply_reset();
    put(3, 2'b00, 32'hA1);
    @(negedge clk);
    checks++;
    if (drop_pulse[3] !== 1'b0) begin
      errors++;
      $display("FAIL drop_early got %b required 0", drop_pulse[3]);
    end
    @(negedge clk);
    checks++;
    if (drop_pulse[3] !== 1'b1) begin
      errors++;
      $display("FAIL drop_pulse got %b required 1", drop_pulse[3]);
    end
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      pulses += $countones(drop_pulse);
    end
    checks++;
    if (pulses != 0) begin
      errors++;
      $display("FAIL drop_single got %0d extra pulses required 0", pulses);
    end
    @(posedge clk);
    #1;
    wait_drain("malformed");
  endtask

  task automatic test_reset_mid_packet();
    int pulses = 0;
    apply_reset();
    out_ready[2] = 1'b0;
    put(0, 2'b01, 32'h0002);
    put(0, 2'b00, 32'h0BB0);
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    checks++;
    if (out_valid !== '0 || in_ready !== '0 || out_data !== '0) begin
      errors++;
      $display("FAIL midreset_outputs got vld %b rdy %b required 0000 0000", out_valid, in_ready);
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
    out_ready = '1;
    @(posedge clk);
    #1;
    put(0, 2'b10, 32'h0CC0);
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      pulses += $countones(drop_pulse);
    end
    checks++;
    if (pulses != 1) begin
      errors++;
      $display("FAIL midreset_tail_drop got %0d pulses required 1", pulses);
    end
    @(posedge clk);
    #1;
    wait_drain("midreset");
  endtask

  initial begin
    test_reset();
    test_single();
    test_wormhole();
    test_round_robin();
    test_backpressure();
    test_malformed();
    test_reset_mid_packet();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
